fnd_display_scheduler: RTL and testbench
========================================

Name: fnd_display_scheduler

Overview:
Shares the single 4-digit FND between four 8-bit register sources (slv_reg0..3), deciding which value is shown and for how long. It supports manual one-hot selection from sw, timed round-robin auto-rotation, and change-triggered preemption that temporarily shows a register whose value just changed. It sits between the AXI/SPI/I2C slave register bank and the FND decimal scan controller, feeding that controller's 8-bit Digit input.

Parameters:
TICK_DIV, 100_000, clk cycles per 1 ms scheduling tick (100 MHz clock).
DWELL_MS, 1000, ticks each source is shown in AUTO.
HOLD_MS, 2000, ticks a changed source is shown in HOLD.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
sw  input  4  one-hot manual source select
auto_en  input  1  enables auto-rotation when sw==0
slv_reg0  input  8  source 0 value
slv_reg1  input  8  source 1 value
slv_reg2  input  8  source 2 value
slv_reg3  input  8  source 3 value
disp_value  output  8  value to FND controller
disp_src  output  2  index of displayed source
disp_valid  output  1  1 = a source is displayed; 0 = blank/idle
disp_hold  output  1  1 while in HOLD (DP/blink indicator)

Behaviour:
- Reset: asserted when reset=0, asynchronous. All outputs 0, state IDLE, prescaler 0, dwell counter 0, pending 0, prime flag 0.
- Tick: free-running prescaler pulses ms_tick for 1 clk every TICK_DIV clks.
- States: IDLE, MANUAL, AUTO, HOLD. Mode decode is evaluated every cycle, highest priority first:
  - sw exactly one-hot: MANUAL with src = bit index; pending cleared.
  - sw multi-hot: IDLE; pending cleared.
  - sw==0 with auto_en=0: IDLE; pending cleared.
  - sw==0 with auto_en=1: AUTO/HOLD rules below. IDLE/MANUAL→AUTO starts at src 0 with dwell counter 0.
- AUTO: on ms_tick with dwell_cnt==DWELL_MS-1, src←(src+1) mod 4 (3 wraps to 0) and dwell_cnt←0. Otherwise dwell_cnt increments on ms_tick.
- Change detection: a prev copy of all four regs is captured every cycle.
  - The first cycle after reset release only loads prev (prime flag), so no detection then.
  - chg[i] = slv_reg_i != prev_i.
  - In AUTO/HOLD, chg bits OR into pending[3:0]. In IDLE/MANUAL, changes are ignored.
- AUTO with pending≠0: next cycle enter HOLD with src = lowest pending index; that bit is cleared and the hold counter set to 0.
- HOLD:
  - A change on the held src restarts the hold counter and does not set pending.
  - Expiry: on ms_tick with hold_cnt==HOLD_MS-1. If pending≠0, serve the lowest pending index (re-enter HOLD). Otherwise return to AUTO with src=(held src+1) mod 4 and dwell_cnt=0.
- Simultaneous changes: all bits are set; they are served in ascending index order.
- Outputs are registered, with 1-cycle latency from sw/state decision. disp_value tracks the live slv_reg[src] (1-cycle latency) in MANUAL/AUTO/HOLD.
- disp_valid=1 in MANUAL/AUTO/HOLD. disp_hold=1 only in HOLD.
- IDLE outputs: disp_value=0, disp_src=0, disp_valid=0.
- Reset asserted mid-operation aborts immediately. There is no resume state.

Decomposition:
- Shared package: state encoding constants (IDLE=0, MANUAL=1, AUTO=2, HOLD=3), NUM_SRC=4, SRC_W=2.
- One sub-module: fnd_tick_gen (prescaler producing ms_tick; parameter TICK_DIV; ports clk, reset, tick).
- Scheduler FSM, counters and change detection stay in fnd_display_scheduler.

Test Plan:
Bench parameters: TICK_DIV=4, DWELL_MS=3, HOLD_MS=5.
- Manual select: release reset, slv_reg0=123, sw=0001 → one clk later disp_valid=1, disp_src=0, disp_value=123, disp_hold=0. slv_reg0→45 → disp_value=45 next clk.
- Auto rotation: sw=0, auto_en=1, regs static (10,20,30,40) → disp_src 0,1,2,3,0 each held 12 clks (±3 on first dwell), values 10,20,30,40.
- Preemption: AUTO showing src1, slv_reg3 5→9 → next clk HOLD, disp_src=3, disp_value=9, disp_hold=1 for 20 clks (±3), then AUTO disp_src=0, disp_hold=0.
- Simultaneous changes: in AUTO, slv_reg0 and slv_reg2 change in the same clk → HOLD src0 (20 clks), HOLD src2 (20 clks), then AUTO src3.
- Override and multi-hot: during HOLD set sw=1000 → next clk MANUAL, disp_src=3, disp_hold=0, pending cleared. Return to sw=0 → AUTO src0 with no HOLD. sw=0110 → disp_valid=0, disp_value=0.
- Reset mid-HOLD: drive reset=0 → outputs 0 immediately without a clk. Release with regs nonzero, auto_en=1 → AUTO src0 with no spurious HOLD.

Source files
------------

// File: rtl/fnd_display_scheduler_pkg.sv
// Shared types and constants for the FND display scheduler.
package fnd_display_scheduler_pkg;

  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef logic [SRC_W-1:0]   src_t;
  typedef logic [NUM_SRC-1:0] src_mask_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic src_t lowest_index(input src_mask_t vec);
    src_t idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = src_t'(i);
    end
    return idx;
  endfunction

  // One-hot mask for a source index.
  function automatic src_mask_t src_mask(input src_t idx);
    return src_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module fnd_tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the terminal count, then wrap to zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cnt_d = cnt_q + CNT_W'(1);
    tick  = 1'b0;
    if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
      tick  = 1'b1;
      cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fnd_display_scheduler.sv
// Chooses which of four register sources drives the FND and for how long:
// manual one-hot select, timed round-robin, and change-triggered hold.
module fnd_display_scheduler
  import fnd_display_scheduler_pkg::*;
#(
  parameter int TICK_DIV = 100_000,
  parameter int DWELL_MS = 1000,
  parameter int HOLD_MS  = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        sw,
  input  logic              auto_en,
  input  logic [DATA_W-1:0] slv_reg0,
  input  logic [DATA_W-1:0] slv_reg1,
  input  logic [DATA_W-1:0] slv_reg2,
  input  logic [DATA_W-1:0] slv_reg3,
  output logic [DATA_W-1:0] disp_value,
  output logic [SRC_W-1:0]  disp_src,
  output logic              disp_valid,
  output logic              disp_hold
);

  localparam int DWELL_W = $clog2(DWELL_MS + 1);
  localparam int HOLD_W  = $clog2(HOLD_MS + 1);

  logic                           ms_tick;
  logic [NUM_SRC-1:0][DATA_W-1:0] regs;
  logic [NUM_SRC-1:0][DATA_W-1:0] prev_q;
  logic                           prime_q;
  src_mask_t                      chg;

  state_e                         state_q, state_d;
  src_t                           src_q, src_d;
  logic [DWELL_W-1:0]             dwell_q, dwell_d;
  logic [HOLD_W-1:0]              hold_q, hold_d;
  src_mask_t                      pending_q, pending_d;

  src_mask_t                      pend_eff;
  src_mask_t                      held_mask;
  logic                           dwell_last;
  logic                           hold_last;

  logic [DATA_W-1:0]              disp_value_q, disp_value_d;
  src_t                           disp_src_q, disp_src_d;
  logic                           disp_valid_q, disp_valid_d;
  logic                           disp_hold_q, disp_hold_d;

  fnd_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (ms_tick)
  );

  assign regs = {slv_reg3, slv_reg2, slv_reg1, slv_reg0};

  // Per-source change flags; suppressed on the first cycle after reset
  // because prev has not yet been loaded with real register values.
  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      chg[i] = prime_q && (regs[i] != prev_q[i]);
    end
  end

  // Snapshot of all sources, compared against next cycle's values.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: this small register array is reset so the post-reset state is fully defined.
    if (!reset) begin
      prev_q  <= '0;
      prime_q <= 1'b0;
    end else begin
      prev_q  <= regs;
      prime_q <= 1'b1;
    end
  end

  assign dwell_last = (dwell_q == DWELL_W'(DWELL_MS - 1));
  assign hold_last  = (hold_q  == HOLD_W'(HOLD_MS - 1));

  // Mode decode and scheduler next state. Changes seen this cycle are
  // merged combinationally so a preemption shows on the very next clock.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dwell_d   = dwell_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    pend_eff  = pending_q;
    held_mask = src_mask(src_q);

    if ($onehot(sw)) begin
      state_d   = ST_MANUAL;
      src_d     = lowest_index(sw);
      dwell_d   = '0;
      hold_d    = '0;
      pending_d = '0;
    end else if ((sw != 4'b0000) || !auto_en) begin
      state_d   = ST_IDLE;
      src_d     = '0;
      dwell_d   = '0;
      hold_d    = '0;
      pending_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_MANUAL: begin
          state_d   = ST_AUTO;
          src_d     = '0;
          dwell_d   = '0;
          hold_d    = '0;
          pending_d = '0;
        end
        ST_AUTO: begin
          pend_eff  = pending_q | chg;
          pending_d = pend_eff;
          if (pend_eff != '0) begin
            state_d   = ST_HOLD;
            src_d     = lowest_index(pend_eff);
            pending_d = pend_eff & ~src_mask(lowest_index(pend_eff));
            hold_d    = '0;
          end else if (ms_tick) begin
            if (dwell_last) begin
              src_d   = src_t'(src_q + 1'b1);
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + DWELL_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // A change on the held source only extends the hold.
          pend_eff  = pending_q | (chg & ~held_mask);
          pending_d = pend_eff;
          if ((chg & held_mask) != '0) begin
            hold_d = '0;
          end else if (ms_tick) begin
            if (hold_last) begin
              if (pend_eff != '0) begin
                src_d     = lowest_index(pend_eff);
                pending_d = pend_eff & ~src_mask(lowest_index(pend_eff));
                hold_d    = '0;
              end else begin
                state_d = ST_AUTO;
                src_d   = src_t'(src_q + 1'b1);
                dwell_d = '0;
              end
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dwell_q   <= '0;
      hold_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dwell_q   <= dwell_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
    end
  end

  // Output values derived from the state being entered; blank when idle.
  always_comb begin
    disp_value_d = '0;
    disp_src_d   = '0;
    disp_valid_d = 1'b0;
    disp_hold_d  = 1'b0;
    if (state_d != ST_IDLE) begin
      disp_value_d = regs[src_d];
      disp_src_d   = src_d;
      disp_valid_d = 1'b1;
      disp_hold_d  = (state_d == ST_HOLD);
    end
  end

  // Registered outputs towards the FND scan controller.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_value_q <= '0;
      disp_src_q   <= '0;
      disp_valid_q <= 1'b0;
      disp_hold_q  <= 1'b0;
    end else begin
      disp_value_q <= disp_value_d;
      disp_src_q   <= disp_src_d;
      disp_valid_q <= disp_valid_d;
      disp_hold_q  <= disp_hold_d;
    end
  end

  assign disp_value = disp_value_q;
  assign disp_src   = disp_src_q;
  assign disp_valid = disp_valid_q;
  assign disp_hold  = disp_hold_q;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Self-checking bench: directed scenarios plus random stimulus, compared
// every cycle against a behavioural model of the scheduling rules.
module tb_fnd_display_scheduler;

  localparam int TICK_DIV = 4;
  localparam int DWELL_MS = 3;
  localparam int HOLD_MS  = 5;

  localparam int M_IDLE   = 0;
  localparam int M_MANUAL = 1;
  localparam int M_AUTO   = 2;
  localparam int M_HOLD   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       auto_en;
  logic [7:0] reg_in [4];
  logic [7:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [7:0] disp_value;
  logic [1:0] disp_src;
  logic       disp_valid;
  logic       disp_hold;

  assign slv_reg0 = reg_in[0];
  assign slv_reg1 = reg_in[1];
  assign slv_reg2 = reg_in[2];
  assign slv_reg3 = reg_in[3];

  fnd_display_scheduler #(
    .TICK_DIV (TICK_DIV),
    .DWELL_MS (DWELL_MS),
    .HOLD_MS  (HOLD_MS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .auto_en    (auto_en),
    .slv_reg0   (slv_reg0),
    .slv_reg1   (slv_reg1),
    .slv_reg2   (slv_reg2),
    .slv_reg3   (slv_reg3),
    .disp_value (disp_value),
    .disp_src   (disp_src),
    .disp_valid (disp_valid),
    .disp_hold  (disp_hold)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural model state.
  int       m_mode, m_src, m_dwell, m_hold, m_cyc;
  bit       m_primed;
  bit [3:0] m_pend;
  int       m_prev [4];
  int       exp_value, exp_src, exp_valid, exp_hold;

  task automatic model_reset();
    m_mode = M_IDLE; m_src = 0; m_dwell = 0; m_hold = 0; m_cyc = 0;
    m_primed = 0; m_pend = '0;
    for (int i = 0; i < 4; i++) m_prev[i] = 0;
    exp_value = 0; exp_src = 0; exp_valid = 0; exp_hold = 0;
  endtask

  // Serve the lowest-numbered pending source with a fresh hold.
  task automatic model_serve();
    bit done;
    done = 0;
    for (int i = 0; i < 4; i++) begin
      if (!done && m_pend[i]) begin
        done = 1; m_mode = M_HOLD; m_src = i; m_pend[i] = 0; m_hold = 0;
      end
    end
  endtask

  // One clock of the scheduling rules applied to the current inputs.
  task automatic model_step();
    bit       tick;
    bit [3:0] changed;
    bit       held_changed;
    int       ones;
    tick = (m_cyc % TICK_DIV) == TICK_DIV - 1;
    for (int i = 0; i < 4; i++) changed[i] = m_primed && (int'(reg_in[i]) != m_prev[i]);
    ones = $countones(sw);
    if (ones == 1) begin
      m_mode = M_MANUAL;
      for (int i = 0; i < 4; i++) if (sw[i]) m_src = i;
      m_pend = '0; m_dwell = 0; m_hold = 0;
    end else if (ones > 1 || !auto_en) begin
      m_mode = M_IDLE; m_src = 0; m_pend = '0; m_dwell = 0; m_hold = 0;
    end else if (m_mode == M_IDLE || m_mode == M_MANUAL) begin
      m_mode = M_AUTO; m_src = 0; m_pend = '0; m_dwell = 0; m_hold = 0;
    end else if (m_mode == M_AUTO) begin
      m_pend |= changed;
      if (m_pend != 0) model_serve();
      else if (tick) begin
        if (m_dwell == DWELL_MS - 1) begin
          m_src = (m_src + 1) % 4; m_dwell = 0;
        end else m_dwell++;
      end
    end else begin
      held_changed = changed[m_src];
      changed[m_src] = 0;
      m_pend |= changed;
      if (held_changed) m_hold = 0;
      else if (tick) begin
        if (m_hold == HOLD_MS - 1) begin
          if (m_pend != 0) model_serve();
          else begin
            m_mode = M_AUTO; m_src = (m_src + 1) % 4; m_dwell = 0;
          end
        end else m_hold++;
      end
    end
    for (int i = 0; i < 4; i++) m_prev[i] = reg_in[i];
    m_primed = 1;
    m_cyc++;
    if (m_mode == M_IDLE) begin
      exp_value = 0; exp_src = 0; exp_valid = 0; exp_hold = 0;
    end else begin
      exp_value = reg_in[m_src]; exp_src = m_src; exp_valid = 1;
      exp_hold = (m_mode == M_HOLD) ? 1 : 0;
    end
  endtask

  // Advance one clock and compare all outputs against the model.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("disp_value", disp_value, exp_value);
    check("disp_src",   disp_src,   exp_src);
    check("disp_valid", disp_valid, exp_valid);
    check("disp_hold",  disp_hold,  exp_hold);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Run until the model reaches the given mode/source, within a budget.
  task automatic wait_for(input int mode, input int src, input int budget, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (m_mode == mode && m_src == src) found = 1;
      else cycle();
    end
    check(tag, found, 1);
  endtask

  initial begin
    int r;
    reset = 1'b0; sw = 4'b0000; auto_en = 1'b0;
    for (int i = 0; i < 4; i++) reg_in[i] = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_value", disp_value, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_hold",  disp_hold,  0);
    check("rst_src",   disp_src,   0);
    reset = 1'b1;

    // Manual select tracks the live register.
    reg_in[0] = 8'd123; sw = 4'b0001;
    cycle();
    check("man_value", disp_value, 123);
    check("man_valid", disp_valid, 1);
    reg_in[0] = 8'd45;
    cycle();
    check("man_track", disp_value, 45);

    // Auto rotation with static registers (changes in MANUAL are ignored).
    reg_in[0] = 8'd10; reg_in[1] = 8'd20; reg_in[2] = 8'd30; reg_in[3] = 8'd5;
    cycle();
    sw = 4'b0000; auto_en = 1'b1;
    run(60);

    // Preemption: change source 3 while source 1 is shown.
    wait_for(M_AUTO, 1, 100, "wait_src1");
    reg_in[3] = 8'd9;
    cycle();
    check("pre_src",   disp_src,   3);
    check("pre_value", disp_value, 9);
    check("pre_hold",  disp_hold,  1);
    wait_for(M_AUTO, 0, 60, "pre_return_src0");
    check("pre_ret_hold", disp_hold, 0);

    // Simultaneous changes served in ascending order.
    reg_in[0] = 8'd11; reg_in[2] = 8'd33;
    cycle();
    check("sim_src0", disp_src, 0);
    check("sim_hold", disp_hold, 1);
    wait_for(M_HOLD, 2, 60, "sim_src2");
    wait_for(M_AUTO, 3, 60, "sim_src3");

    // Override during HOLD, then multi-hot.
    wait_for(M_AUTO, 0, 100, "ovr_wait_src0");
    reg_in[1] = 8'd77;
    cycle();
    run(3);
    reg_in[2] = 8'd88;
    cycle();
    sw = 4'b1000;
    cycle();
    check("ovr_src",  disp_src,  3);
    check("ovr_hold", disp_hold, 0);
    sw = 4'b0000;
    cycle();
    check("ovr_auto_src",  disp_src,  0);
    check("ovr_auto_hold", disp_hold, 0);
    run(15);
    sw = 4'b0110;
    cycle();
    check("mh_valid", disp_valid, 0);
    check("mh_value", disp_value, 0);

    // Reset in the middle of a HOLD.
    sw = 4'b0000;
    run(2);
    reg_in[1] = 8'd5;
    cycle();
    check("rh_hold", disp_hold, 1);
    run(3);
    #2 reset = 1'b0;
    #1;
    check("rh_async_value", disp_value, 0);
    check("rh_async_valid", disp_valid, 0);
    check("rh_async_hold",  disp_hold,  0);
    check("rh_async_src",   disp_src,   0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cycle();
    check("rh_rel_src",   disp_src,   0);
    check("rh_rel_hold",  disp_hold,  0);
    check("rh_rel_valid", disp_valid, 1);
    run(30);

    // Random stimulus.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 9);
        if (r <= 5)      sw = 4'b0000;
        else if (r <= 8) sw = 4'b0001 << $urandom_range(0, 3);
        else             sw = 4'($urandom_range(0, 15));
        auto_en = ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 24) == 0) reg_in[$urandom_range(0, 3)] = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) == 1) reg_in[i] = 8'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
